// File: rtl/sparse_weight_encoder.sv
// sparse_weight_encoder
//   Turns a dense weight matrix, streamed one column per beat, into the
//   per-PE compressed-column arrays (w, z, p) consumed by the sparse
//   matrix-vector accelerator. Each column is encoded in the cycle it is
//   accepted; the finished matrix is held stable until downstream takes it.
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     column beat handshake
//   in_last               framing marker, expected on column W_COL-1
//   in_col[r]             dense column, element r = matrix row r
//   out_valid/out_ready   encoded-matrix handshake
//   w_out[e][s]           nonzero weights of PE e, compacted in scan order
//   z_out[e][s]           zero-run preceding w_out[e][s] within its column
//   p_out[e][c]           index of the first slot of column c for PE e;
//                         p_out[e][W_COL] is the total nonzero count
//   err_last              sticky framing error, cleared only by reset
//
// Handshake rule (both ports): a transfer happens at a rising edge where
// valid and ready are both 1. in_ready and out_valid are flops, so neither
// depends combinationally on in_valid or out_ready.
module sparse_weight_encoder #(
   parameter int PE_NUM = 4,
   parameter int W_ROW  = 16,
   parameter int W_COL  = 8,
   parameter int BW_W   = 8,
   parameter int BW_P   = 7,
   parameter int BW_Z   = 3
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_last,
   input  logic signed [BW_W-1:0] in_col [W_ROW],
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [BW_W-1:0] w_out  [PE_NUM][W_ROW*W_COL/PE_NUM],
   output logic        [BW_Z-1:0] z_out  [PE_NUM][W_ROW*W_COL/PE_NUM],
   output logic        [BW_P-1:0] p_out  [PE_NUM][W_COL+1],
   output logic                   err_last
);

   localparam int RPE   = W_ROW / PE_NUM;           // local rows per PE
   localparam int NSLOT = W_ROW * W_COL / PE_NUM;   // w/z slots per PE
   localparam int SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
   localparam int CW    = $clog2(W_COL + 1);
   localparam logic [CW-1:0] LAST_COL = CW'(W_COL - 1);

   typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

   state_t          state;
   logic [CW-1:0]   col_cnt;
   logic [BW_P-1:0] cnt     [PE_NUM];
   logic [BW_P-1:0] new_cnt [PE_NUM];
   logic            wr_en   [PE_NUM][RPE];
   logic [SW-1:0]   wr_slot [PE_NUM][RPE];
   logic [BW_Z-1:0] wr_run  [PE_NUM][RPE];

   logic accept;
   logic last_col;

   assign accept   = in_valid & in_ready;
   assign last_col = (col_cnt == LAST_COL);

   // Per-PE scan of the incoming column: every nonzero local row gets the
   // next free slot and the count of zero rows skipped since the previous
   // nonzero of this column (or since q=0).
   always_comb begin : encode
      logic [BW_P-1:0] k;
      logic [BW_Z-1:0] run;
      logic            nz;
      k   = '0;
      run = '0;
      nz  = 1'b0;
      for (int e = 0; e < PE_NUM; e++) begin
         k   = cnt[e];
         run = '0;
         for (int q = 0; q < RPE; q++) begin
            nz = (in_col[q*PE_NUM+e] != '0);
            wr_en[e][q]   = nz;
            wr_slot[e][q] = k[SW-1:0];
            wr_run[e][q]  = run;
            if (nz) begin
               k   = k + BW_P'(1);
               run = '0;
            end else begin
               run = run + BW_Z'(1);
            end
         end
         new_cnt[e] = k;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= COLLECT;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         col_cnt   <= '0;
         err_last  <= 1'b0;
         for (int e = 0; e < PE_NUM; e++) begin
            cnt[e] <= '0;
            for (int s = 0; s < NSLOT; s++) begin
               w_out[e][s] <= '0;
               z_out[e][s] <= '0;
            end
            for (int c = 0; c <= W_COL; c++) p_out[e][c] <= '0;
         end
      end else begin
         case (state)
            COLLECT: begin
               if (accept) begin
                  // Framing is only reported; the column counter alone
                  // decides where the matrix ends.
                  if (in_last != last_col) err_last <= 1'b1;
                  for (int e = 0; e < PE_NUM; e++) begin
                     p_out[e][col_cnt] <= cnt[e];
                     cnt[e]            <= new_cnt[e];
                     for (int q = 0; q < RPE; q++) begin
                        if (wr_en[e][q]) begin
                           w_out[e][wr_slot[e][q]] <= in_col[q*PE_NUM+e];
                           z_out[e][wr_slot[e][q]] <= wr_run[e][q];
                        end
                     end
                  end
                  if (last_col) begin
                     for (int e = 0; e < PE_NUM; e++) p_out[e][W_COL] <= new_cnt[e];
                     col_cnt   <= '0;
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     col_cnt <= col_cnt + CW'(1);
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  for (int e = 0; e < PE_NUM; e++) begin
                     cnt[e] <= '0;
                     for (int s = 0; s < NSLOT; s++) begin
                        w_out[e][s] <= '0;
                        z_out[e][s] <= '0;
                     end
                     for (int c = 0; c <= W_COL; c++) p_out[e][c] <= '0;
                  end
                  state     <= COLLECT;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= COLLECT;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sparse_weight_encoder.sv
// Testbench for sparse_weight_encoder: directed and randomized matrices,
// checked against a behavioural model of the compressed-column format.
module tb_sparse_weight_encoder;

   localparam int PE_NUM = 4;
   localparam int W_ROW  = 16;
   localparam int W_COL  = 8;
   localparam int BW_W   = 8;
   localparam int BW_P   = 7;
   localparam int BW_Z   = 3;
   localparam int RPE    = W_ROW / PE_NUM;
   localparam int NSLOT  = W_ROW * W_COL / PE_NUM;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic                   in_valid;
   logic                   in_ready;
   logic                   in_last;
   logic signed [BW_W-1:0] in_col [W_ROW];
   logic                   out_valid;
   logic                   out_ready;
   logic signed [BW_W-1:0] w_out  [PE_NUM][NSLOT];
   logic        [BW_Z-1:0] z_out  [PE_NUM][NSLOT];
   logic        [BW_P-1:0] p_out  [PE_NUM][W_COL+1];
   logic                   err_last;

   sparse_weight_encoder #(
      .PE_NUM(PE_NUM), .W_ROW(W_ROW), .W_COL(W_COL),
      .BW_W(BW_W), .BW_P(BW_P), .BW_Z(BW_Z)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in_col(in_col),
      .out_valid(out_valid), .out_ready(out_ready),
      .w_out(w_out), .z_out(z_out), .p_out(p_out),
      .err_last(err_last)
   );

   // ---------------- scoreboard state ----------------
   int          checks   = 0;
   int          failures = 0;
   int          mat   [W_ROW][W_COL];
   int          exp_w [PE_NUM][NSLOT];
   int          exp_z [PE_NUM][NSLOT];
   int          exp_p [PE_NUM][W_COL+1];
   logic [31:0] exp_q [$];
   bit          err_model = 1'b0;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: walk each PE's rows column by column; the zero-run is the
   // distance in local rows from the previous nonzero (start counts as q=-1).
   function automatic void build_model();
      int n;
      int prev;
      for (int e = 0; e < PE_NUM; e++) begin
         n = 0;
         for (int s = 0; s < NSLOT; s++) begin
            exp_w[e][s] = 0;
            exp_z[e][s] = 0;
         end
         for (int c = 0; c < W_COL; c++) begin
            exp_p[e][c] = n;
            prev = -1;
            for (int q = 0; q < RPE; q++) begin
               if (mat[q*PE_NUM+e][c] != 0) begin
                  exp_w[e][n] = mat[q*PE_NUM+e][c];
                  exp_z[e][n] = q - prev - 1;
                  prev = q;
                  n++;
               end
            end
         end
         exp_p[e][W_COL] = n;
      end
   endfunction

   function automatic void rand_mat(input int density);
      for (int r = 0; r < W_ROW; r++)
         for (int c = 0; c < W_COL; c++)
            mat[r][c] = ($urandom_range(0, 99) < density) ?
                        (int'($urandom_range(0, 255)) - 128) : 0;
   endfunction

   task automatic check_matrix(input string tag);
      build_model();
      exp_q.delete();
      for (int e = 0; e < PE_NUM; e++) begin
         for (int s = 0; s < NSLOT; s++) exp_q.push_back(exp_w[e][s]);
         for (int s = 0; s < NSLOT; s++) exp_q.push_back(exp_z[e][s]);
         for (int c = 0; c <= W_COL; c++) exp_q.push_back(exp_p[e][c]);
      end
      for (int e = 0; e < PE_NUM; e++) begin
         for (int s = 0; s < NSLOT; s++)
            check($sformatf("%s_w[%0d][%0d]", tag, e, s), w_out[e][s], exp_q.pop_front());
         for (int s = 0; s < NSLOT; s++)
            check($sformatf("%s_z[%0d][%0d]", tag, e, s), z_out[e][s], exp_q.pop_front());
         for (int c = 0; c <= W_COL; c++)
            check($sformatf("%s_p[%0d][%0d]", tag, e, c), p_out[e][c], exp_q.pop_front());
      end
   endtask

   task automatic check_zero(input string tag);
      for (int e = 0; e < PE_NUM; e++) begin
         for (int s = 0; s < NSLOT; s++) begin
            check($sformatf("%s_w[%0d][%0d]", tag, e, s), w_out[e][s], 0);
            check($sformatf("%s_z[%0d][%0d]", tag, e, s), z_out[e][s], 0);
         end
         for (int c = 0; c <= W_COL; c++)
            check($sformatf("%s_p[%0d][%0d]", tag, e, c), p_out[e][c], 0);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic load_col(input int c, input bit last);
      int gap;
      int n;
      int v;
      gap = $urandom_range(0, 1);
      @(negedge clk);
      repeat (gap) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      for (int r = 0; r < W_ROW; r++) begin
         v = mat[r][c];
         in_col[r] = v[BW_W-1:0];
      end
      in_last  = last;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("in_ready_col%0d", c), in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (last != (c == W_COL - 1)) err_model = 1'b1;
   endtask

   task automatic send_matrix(input string tag, input int last_beat);
      for (int c = 0; c < W_COL; c++) begin
         load_col(c, c == last_beat);
         check($sformatf("%s_err_c%0d", tag, c), err_last, err_model);
         check($sformatf("%s_ovalid_c%0d", tag, c), out_valid, (c == W_COL - 1));
      end
   endtask

   task automatic take_output(input string tag);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_ovalid_after_take"}, out_valid, 0);
      check({tag, "_iready_after_take"}, in_ready, 1);
      check_zero({tag, "_cleared"});
   endtask

   // ---------------- directed + random sequence ----------------
   int p1_exp [W_COL+1];

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      for (int r = 0; r < W_ROW; r++) in_col[r] = '0;
      repeat (2) @(negedge clk);
      check("rst_ovalid", out_valid, 0);
      check("rst_err", err_last, 0);
      check_zero("rst");
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_iready", in_ready, 1);

      // all-zero matrix
      for (int r = 0; r < W_ROW; r++)
         for (int c = 0; c < W_COL; c++) mat[r][c] = 0;
      send_matrix("zero", W_COL - 1);
      check_matrix("zero");
      take_output("zero");

      // diagonal: column c holds only row c with value c+1
      for (int r = 0; r < W_ROW; r++)
         for (int c = 0; c < W_COL; c++) mat[r][c] = (r == c) ? c + 1 : 0;
      send_matrix("diag", W_COL - 1);
      check_matrix("diag");
      for (int e = 0; e < PE_NUM; e++) begin
         check($sformatf("diag_w0_e%0d", e), w_out[e][0], e + 1);
         check($sformatf("diag_w1_e%0d", e), w_out[e][1], e + 5);
         check($sformatf("diag_z1_e%0d", e), z_out[e][1], 1);
         check($sformatf("diag_pend_e%0d", e), p_out[e][W_COL], 2);
      end
      p1_exp = '{0, 0, 1, 1, 1, 1, 2, 2, 2};
      for (int c = 0; c <= W_COL; c++)
         check($sformatf("diag_p1_%0d", c), p_out[1][c], p1_exp[c]);
      take_output("diag");

      // dense all -1
      for (int r = 0; r < W_ROW; r++)
         for (int c = 0; c < W_COL; c++) mat[r][c] = -1;
      send_matrix("neg1", W_COL - 1);
      check_matrix("neg1");
      for (int e = 0; e < PE_NUM; e++)
         for (int c = 0; c <= W_COL; c++)
            check($sformatf("neg1_p_%0d_%0d", e, c), p_out[e][c], 4 * c);
      take_output("neg1");

      // random matrices at several densities
      for (int i = 0; i < 3; i++) begin
         rand_mat(30 + 35 * i);
         send_matrix($sformatf("rand%0d", i), W_COL - 1);
         check_matrix($sformatf("rand%0d", i));
         take_output($sformatf("rand%0d", i));
      end

      // backpressure: in_valid held high during HOLD must be ignored
      rand_mat(50);
      send_matrix("bp", W_COL - 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_last  = 1'($urandom_range(0, 1));
         for (int r = 0; r < W_ROW; r++) in_col[r] = BW_W'($urandom_range(0, 255));
         @(posedge clk);
         #1;
         check($sformatf("bp_iready_%0d", i), in_ready, 0);
         check($sformatf("bp_ovalid_%0d", i), out_valid, 1);
         check_matrix($sformatf("bp_hold%0d", i));
      end
      in_last = 1'b0;
      take_output("bp");
      rand_mat(60);
      send_matrix("bp_next", W_COL - 1);
      check_matrix("bp_next");
      take_output("bp_next");

      // framing: early in_last on beat 3, error persists into next matrix
      rand_mat(50);
      send_matrix("frame", 3);
      check_matrix("frame");
      take_output("frame");
      rand_mat(50);
      send_matrix("frame_next", W_COL - 1);
      check_matrix("frame_next");
      check("frame_err_sticky", err_last, 1);
      take_output("frame_next");

      // reset in the middle of a matrix
      rand_mat(80);
      for (int c = 0; c < 4; c++) load_col(c, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      err_model = 1'b0;
      check("midrst_ovalid", out_valid, 0);
      check("midrst_err", err_last, 0);
      check_zero("midrst");
      @(negedge clk);
      reset_n = 1'b1;
      rand_mat(40);
      send_matrix("after_rst", W_COL - 1);
      check_matrix("after_rst");
      take_output("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
